// File: rtl/ecg_finn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecg_finn_pkg
// Purpose  : Shared types and default sizing for the ECG window feeder that
//            slices a raw ECG sample stream into (overlapping) windows for a
//            FINN inference core.
// Contents : WIN_LEN_DEF / STRIDE_DEF defaults, sample_t byte type,
//            state_t FILL/EMIT enum.
// Revision : 1.0 - initial release
// ============================================================================
package ecg_finn_pkg;

    localparam int WIN_LEN_DEF = 144;
    localparam int STRIDE_DEF  = 72;

    typedef logic [7:0] sample_t;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage : ecg_finn_pkg
`default_nettype wire

// File: rtl/ecg_window_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : ecg_window_feeder_if
// Purpose  : Bundles the sample input stream (s_axis_0) and the window output
//            stream (m_axis_0) of the ECG window feeder.
// Modports : slave  - feeder view (consumes s_axis_0, produces m_axis_0)
//            master - environment view (produces s_axis_0, consumes m_axis_0)
// Config   : ECG_WIN_TLAST_EN adds m_axis_0_tlast to the bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ecg_window_feeder_if;
    import ecg_finn_pkg::*;

    sample_t s_axis_0_tdata;
    logic    s_axis_0_tvalid;
    logic    s_axis_0_tready;
    sample_t m_axis_0_tdata;
    logic    m_axis_0_tvalid;
    logic    m_axis_0_tready;
`ifdef ECG_WIN_TLAST_EN
    logic    m_axis_0_tlast;

    modport slave (
        input  s_axis_0_tdata, s_axis_0_tvalid, m_axis_0_tready,
        output s_axis_0_tready, m_axis_0_tdata, m_axis_0_tvalid, m_axis_0_tlast
    );
    modport master (
        output s_axis_0_tdata, s_axis_0_tvalid, m_axis_0_tready,
        input  s_axis_0_tready, m_axis_0_tdata, m_axis_0_tvalid, m_axis_0_tlast
    );
`else
    modport slave (
        input  s_axis_0_tdata, s_axis_0_tvalid, m_axis_0_tready,
        output s_axis_0_tready, m_axis_0_tdata, m_axis_0_tvalid
    );
    modport master (
        output s_axis_0_tdata, s_axis_0_tvalid, m_axis_0_tready,
        input  s_axis_0_tready, m_axis_0_tdata, m_axis_0_tvalid
    );
`endif

endinterface : ecg_window_feeder_if
`default_nettype wire

// File: rtl/ecg_win_ram.sv
`default_nettype none
// ============================================================================
// Module   : ecg_win_ram
// Purpose  : DEPTH x 8 circular sample buffer, one synchronous write port and
//            one asynchronous read port.
// Ports    : clk_i    - clock
//            we_i     - write enable
//            waddr_i  - write address
//            wdata_i  - write data
//            raddr_i  - read address
//            rdata_o  - read data (combinational from raddr_i)
// Revision : 1.0 - initial release
// ============================================================================
module ecg_win_ram
    import ecg_finn_pkg::*;
#(
    parameter int DEPTH = WIN_LEN_DEF,
    parameter int AW    = 8
) (
    input  wire logic          clk_i,
    input  wire logic          we_i,
    input  wire logic [AW-1:0] waddr_i,
    input  wire sample_t       wdata_i,
    input  wire logic [AW-1:0] raddr_i,
    output sample_t            rdata_o
);

    // Contents are intentionally not reset.
    sample_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : ecg_win_ram
`default_nettype wire

// File: rtl/ecg_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ecg_window_feeder
// Purpose  : Collects ECG samples into a WIN_LEN-deep circular buffer and
//            emits each window oldest-first toward a FINN core. The first
//            window after reset needs WIN_LEN fresh samples, every later one
//            STRIDE fresh samples (windows overlap by WIN_LEN-STRIDE).
// Ports    : ap_clk    - clock (rising edge)
//            ap_rst    - synchronous active-high reset
//            axis      - s_axis_0 sample input / m_axis_0 window output
//            win_count - number of fully emitted windows (wraps)
// Config   : ECG_WIN_TLAST_EN - drive m_axis_0_tlast on the last byte of
//            every window.
// Revision : 1.0 - initial release
// ============================================================================
module ecg_window_feeder
    import ecg_finn_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int STRIDE  = STRIDE_DEF,
    parameter int CNT_W   = 16
) (
    input  wire logic               ap_clk,
    input  wire logic               ap_rst,
    ecg_window_feeder_if.slave      axis,
    output logic [CNT_W-1:0]        win_count
);

    localparam int              PW         = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int              NW         = $clog2(WIN_LEN + 1);
    localparam logic [PW-1:0]   PTR_LAST   = PW'(WIN_LEN - 1);
    localparam logic [NW-1:0]   CNT_FIRST  = NW'(WIN_LEN);
    localparam logic [NW-1:0]   CNT_LATER  = NW'(STRIDE);

    state_t             state_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [NW-1:0]      new_cnt_q;
    logic               first_q;
    logic [CNT_W-1:0]   win_count_q;
    logic               s_tready_q;
    logic               m_tvalid_q;

    logic [PW-1:0]      wr_ptr_d;
    logic [PW-1:0]      rd_ptr_d;
    logic [PW-1:0]      last_ptr;
    logic [NW-1:0]      new_cnt_d;
    logic               s_hs;
    logic               m_hs;
    logic               fill_done;
    logic               rd_at_last;

    assign s_hs      = axis.s_axis_0_tvalid & s_tready_q;
    assign m_hs      = m_tvalid_q & axis.m_axis_0_tready;
    assign wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    assign new_cnt_d = new_cnt_q + 1'b1;
    assign fill_done = (new_cnt_d == (first_q ? CNT_FIRST : CNT_LATER));

    // The write pointer is frozen during EMIT, so the newest sample (and thus
    // the last byte of the window) sits one slot behind it.
    assign last_ptr   = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
    assign rd_at_last = (rd_ptr_q == last_ptr);

    ecg_win_ram #(
        .DEPTH (WIN_LEN),
        .AW    (PW)
    ) u_ram (
        .clk_i   (ap_clk),
        .we_i    (s_hs),
        .waddr_i (wr_ptr_q),
        .wdata_i (axis.s_axis_0_tdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (axis.m_axis_0_tdata)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            new_cnt_q   <= '0;
            first_q     <= 1'b1;
            win_count_q <= '0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    s_tready_q <= 1'b1;
                    if (s_hs) begin
                        wr_ptr_q  <= wr_ptr_d;
                        new_cnt_q <= new_cnt_d;
                        if (fill_done) begin
                            // Oldest sample lives where the next write would go.
                            state_q    <= ST_EMIT;
                            rd_ptr_q   <= wr_ptr_d;
                            s_tready_q <= 1'b0;
                            m_tvalid_q <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (m_hs) begin
                        rd_ptr_q <= rd_ptr_d;
                        if (rd_at_last) begin
                            state_q     <= ST_FILL;
                            m_tvalid_q  <= 1'b0;
                            s_tready_q  <= 1'b1;
                            new_cnt_q   <= '0;
                            first_q     <= 1'b0;
                            win_count_q <= win_count_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign axis.s_axis_0_tready = s_tready_q;
    assign axis.m_axis_0_tvalid = m_tvalid_q;
    assign win_count            = win_count_q;

`ifdef ECG_WIN_TLAST_EN
    assign axis.m_axis_0_tlast = m_tvalid_q & rd_at_last;
`endif

endmodule : ecg_window_feeder
`default_nettype wire

// File: tb/tb_ecg_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecg_window_feeder
// Purpose  : Scoreboard bench for ecg_window_feeder. Two instances: A with
//            default sizing (overlapping windows), B with STRIDE=WIN_LEN
//            (disjoint windows). A reference model keeps the accepted sample
//            history and queues every expected window byte; the monitor pops
//            and compares whenever a DUT presents a byte.
// Config   : ECG_WIN_TLAST_EN - also checks m_axis_0_tlast.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecg_window_feeder;
    import ecg_finn_pkg::*;

    localparam int WL = 144;
    localparam int SA = 72;
    localparam int SB = 144;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic       stv   [2];
    logic [7:0] s_dat [2];
    logic       mtr   [2];

    logic       o_str [2];
    logic       o_mtv [2];
    logic [7:0] o_mtd [2];
    logic [CW-1:0] wc_a;
    logic [CW-1:0] wc_b;
    logic [CW-1:0] o_wc [2];

    ecg_window_feeder_if ifa ();
    ecg_window_feeder_if ifb ();

    assign ifa.s_axis_0_tdata  = s_dat[0];
    assign ifa.s_axis_0_tvalid = stv[0];
    assign ifa.m_axis_0_tready = mtr[0];
    assign ifb.s_axis_0_tdata  = s_dat[1];
    assign ifb.s_axis_0_tvalid = stv[1];
    assign ifb.m_axis_0_tready = mtr[1];

    assign o_str[0] = ifa.s_axis_0_tready;
    assign o_mtv[0] = ifa.m_axis_0_tvalid;
    assign o_mtd[0] = ifa.m_axis_0_tdata;
    assign o_str[1] = ifb.s_axis_0_tready;
    assign o_mtv[1] = ifb.m_axis_0_tvalid;
    assign o_mtd[1] = ifb.m_axis_0_tdata;
    assign o_wc[0]  = wc_a;
    assign o_wc[1]  = wc_b;

`ifdef ECG_WIN_TLAST_EN
    logic o_mlast [2];
    assign o_mlast[0] = ifa.m_axis_0_tlast;
    assign o_mlast[1] = ifb.m_axis_0_tlast;
`endif

    ecg_window_feeder #(.WIN_LEN(WL), .STRIDE(SA), .CNT_W(CW)) u_dut_a (
        .ap_clk    (clk),
        .ap_rst    (rst[0]),
        .axis      (ifa),
        .win_count (wc_a)
    );

    ecg_window_feeder #(.WIN_LEN(WL), .STRIDE(SB), .CNT_W(CW)) u_dut_b (
        .ap_clk    (clk),
        .ap_rst    (rst[1]),
        .axis      (ifb),
        .win_count (wc_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int d, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d time=%0t", nm, d, act, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: history of accepted samples, queue of expected
    // window bytes {last, data}, and window/reset bookkeeping.
    // ------------------------------------------------------------------
    logic [7:0] hist [2][$];
    logic [8:0] expq [2][$];
    int         since   [2] = '{0, 0};
    bit         first   [2] = '{1'b1, 1'b1};
    bit         rst_prev[2] = '{1'b1, 1'b1};
    int         win_exp [2] = '{0, 0};
    int         mcnt    [2] = '{0, 0};

    function automatic int stride_of(input int d);
        return (d == 0) ? SA : SB;
    endfunction

    always @(negedge clk) begin
        bit exp_tv;
        for (int d = 0; d < 2; d++) begin
            exp_tv = !rst_prev[d] && (expq[d].size() > 0);
            chk("s_tready", d, int'(o_str[d]), int'(!rst_prev[d] && (expq[d].size() == 0)));
            chk("m_tvalid", d, int'(o_mtv[d]), int'(exp_tv));
            chk("win_count", d, int'(o_wc[d]), win_exp[d] % (1 << CW));
            if (exp_tv && o_mtv[d]) begin
                chk("m_tdata", d, int'(o_mtd[d]), int'(expq[d][0][7:0]));
`ifdef ECG_WIN_TLAST_EN
                chk("m_tlast", d, int'(o_mlast[d]), int'(expq[d][0][8]));
`endif
            end

            // Advance the model to the state after the coming rising edge.
            if (rst[d]) begin
                rst_prev[d] = 1'b1;
                hist[d].delete();
                expq[d].delete();
                since[d]   = 0;
                first[d]   = 1'b1;
                win_exp[d] = 0;
                mcnt[d]    = 0;
            end else begin
                rst_prev[d] = 1'b0;
                if (o_mtv[d] && mtr[d] && expq[d].size() > 0) begin
                    mcnt[d]++;
                    if (expq[d][0][8]) begin
                        win_exp[d]++;
                        mcnt[d] = 0;
                    end
                    expq[d].delete(0);
                end
                if (stv[d] && o_str[d]) begin
                    hist[d].push_back(s_dat[d]);
                    while (hist[d].size() > WL) hist[d].delete(0);
                    since[d]++;
                    if (since[d] == (first[d] ? WL : stride_of(d))) begin
                        for (int i = 0; i < WL; i++) begin
                            expq[d].push_back({(i == WL - 1), hist[d][hist[d].size() - WL + i]});
                        end
                        first[d] = 1'b0;
                        since[d] = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus pump: incrementing sample values, AXI-compliant tvalid
    // (held until accepted), configurable tready pattern.
    // vmode: 0 = always valid, 1 = random gaps
    // rmode: 0 = always ready, 1 = 1-on/2-off, 2 = random
    // ------------------------------------------------------------------
    int vmode [2] = '{0, 0};
    int rmode [2] = '{0, 0};
    int mph   [2] = '{0, 0};
    int sval  [2] = '{0, 0};
    bit hs_in [2];

    initial begin
        rst   = '{1'b1, 1'b1};
        stv   = '{1'b1, 1'b1};
        s_dat = '{8'h00, 8'h00};
        mtr   = '{1'b1, 1'b1};
    end

    always begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) hs_in[d] = stv[d] && o_str[d] && !rst[d];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (hs_in[d]) sval[d]++;
            s_dat[d] = 8'(sval[d]);
            if (!(stv[d] && !hs_in[d])) stv[d] = (vmode[d] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case (rmode[d])
                1: begin
                    mph[d] = (mph[d] + 1) % 3;
                    mtr[d] = (mph[d] == 0);
                end
                2:       mtr[d] = ($urandom_range(0, 2) != 0);
                default: mtr[d] = 1'b1;
            endcase
        end
    end

    task automatic wait_wc(input int d, input int target);
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (int'(o_wc[d]) == target) begin
                checks++;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_win_count dut%0d actual=%0d expected=%0d", d, o_wc[d], target);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = '{1'b0, 1'b0};
        fork
            begin
                // Overlapping windows: continuous feed, then stalls, then random.
                wait_wc(0, 1);
                wait_wc(0, 2);
                rmode[0] = 1;
                wait_wc(0, 3);
                vmode[0] = 1;
                rmode[0] = 2;
                wait_wc(0, 6);
                // Abort a window after exactly 50 emitted bytes.
                vmode[0] = 0;
                rmode[0] = 0;
                begin : wait_50
                    for (int c = 0; c < 5000; c++) begin
                        @(negedge clk);
                        #1;
                        if (mcnt[0] == 50) disable wait_50;
                    end
                    failures++;
                    $display("FAIL wait_50_bytes dut0 actual=%0d expected=50", mcnt[0]);
                end
                @(posedge clk);
                #1 rst[0] = 1'b1;
                @(posedge clk);
                #1 rst[0] = 1'b0;
                wait_wc(0, 1);
                vmode[0] = 1;
                rmode[0] = 2;
                wait_wc(0, 2);
            end
            begin
                // Disjoint windows with random backpressure.
                rmode[1] = 2;
                wait_wc(1, 1);
                vmode[1] = 1;
                wait_wc(1, 2);
            end
        join
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ecg_window_feeder
`default_nettype wire
